// File: rtl/alu_pkg.sv
// ALU shared package: data width, shift width, opcode constants, helpers.
// Imported by alu and alu_shifter; optional macro ALU_VARSHIFT_EN lives in alu.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_COMP = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SLLV = 4'b1100;
  localparam logic [3:0] OP_SRLV = 4'b1101;
  localparam logic [3:0] OP_SRAV = 4'b1110;

  function automatic word_t bit_rev(input word_t w);
    word_t r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = w[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// 32-bit log barrel shifter shared by immediate and variable shifts.
// Ports: data, amount, direction (1=left), arithmetic (sign fill), result.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               direction,
  input  logic               arithmetic,
  output logic [DATA_W-1:0]  result
);

  logic [SHAMT_W:0][DATA_W-1:0] stg;
  logic                         fill;

  // Left shifts reuse the right-shift chain on a bit-reversed word.
  assign fill   = arithmetic & ~direction & data[DATA_W-1];
  assign stg[0] = direction ? bit_rev(data) : data;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    localparam int S = 1 << g;
    assign stg[g+1] = amount[g]
                    ? {{S{fill}}, stg[g][DATA_W-1:S]}
                    : stg[g];
  end

  assign result = direction ? bit_rev(stg[SHAMT_W])
                            : stg[SHAMT_W];

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: add/comp/and/xor/sub, immediate and variable shifts.
// Ports: clk, rst, inp1, inp2, shamt, ALUControl -> out, carry_out, isNeg, isZero.
// Define ALU_VARSHIFT_EN to enable variable shifts (codes 1100/1101/1110).
module alu
  import alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] inp1,
  input  logic signed [DATA_W-1:0] inp2,
  input  logic [SHAMT_W-1:0]       shamt,
  input  logic [3:0]               ALUControl,
  output logic signed [DATA_W-1:0] out,
  output logic                     carry_out,
  output logic                     isNeg,
  output logic                     isZero
);

  word_t  sh_res;
  shamt_t sh_amt;
  logic   sh_left;
  logic   sh_arith;
  word_t  res;
  logic   cy;

  // Opcode bit 3 selects the amount source; bits 1:0 pick the shift kind.
  assign sh_amt   = ALUControl[3] ? inp2[SHAMT_W-1:0] : shamt;
  assign sh_left  = (ALUControl[1:0] == 2'b00);
  assign sh_arith = (ALUControl[1:0] == 2'b10);

  alu_shifter u_shifter (
    .data       (inp1),
    .amount     (sh_amt),
    .direction  (sh_left),
    .arithmetic (sh_arith),
    .result     (sh_res)
  );

  always_comb begin
    res = '0;
    cy  = 1'b0;
    case (ALUControl)
      OP_ADD:  {cy, res} = {1'b0, inp1} + {1'b0, inp2};
      OP_COMP: {cy, res} = {1'b0, ~inp2} + 33'd1;
      OP_AND:  res = inp1 & inp2;
      OP_XOR:  res = inp1 ^ inp2;
      OP_SLL,
      OP_SRL,
      OP_SRA:  res = sh_res;
      OP_SUB:  {cy, res} = {1'b0, inp1} + {1'b0, ~inp2} + 33'd1;
`ifdef ALU_VARSHIFT_EN
      OP_SLLV,
      OP_SRLV,
      OP_SRAV: res = sh_res;
`endif
      default: begin
        res = '0;
        cy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      carry_out <= 1'b0;
    end else begin
      out       <= res;
      carry_out <= cy;
    end
  end

  // Flags follow the registered result, so they can never disagree with it.
  assign isNeg  = out[DATA_W-1];
  assign isZero = (out == '0);

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
// Expected values are hand-computed; honours ALU_VARSHIFT_EN if defined.
module tb_alu;
  import alu_pkg::*;

  logic              clk;
  logic              rst;
  logic [31:0]       inp1;
  logic [31:0]       inp2;
  logic [4:0]        shamt;
  logic [3:0]        ALUControl;
  logic signed [31:0] out;
  logic              carry_out;
  logic              isNeg;
  logic              isZero;

  int total;
  int bad;

  alu dut (
    .clk        (clk),
    .rst        (rst),
    .inp1       (inp1),
    .inp2       (inp2),
    .shamt      (shamt),
    .ALUControl (ALUControl),
    .out        (out),
    .carry_out  (carry_out),
    .isNeg      (isNeg),
    .isZero     (isZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [31:0] o,
                           input logic c,
                           input logic n,
                           input logic z);
    check({tag, ".out"},  out, o);
    check({tag, ".cy"},   {31'd0, carry_out}, {31'd0, c});
    check({tag, ".neg"},  {31'd0, isNeg}, {31'd0, n});
    check({tag, ".zero"}, {31'd0, isZero}, {31'd0, z});
  endtask

  task automatic drive(input logic r, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s);
    @(negedge clk);
    rst        = r;
    ALUControl = op;
    inp1       = a;
    inp2       = b;
    shamt      = s;
  endtask

  task automatic step(input logic r, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] s);
    drive(r, op, a, b, s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    ALUControl = OP_ADD;
    inp1       = 32'd5;
    inp2       = 32'd6;
    shamt      = 5'd0;

    step(1'b1, OP_ADD, 32'd5, 32'd6, 5'd0);
    check_all("reset", 32'd0, 1'b0, 1'b0, 1'b1);

    step(1'b0, OP_ADD, 32'd200, 32'd169, 5'd0);
    check_all("add", 32'd369, 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check_all("add_wrap", 32'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    check_all("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    step(1'b0, OP_COMP, 32'd7, 32'd169, 5'd0);
    check_all("comp", 32'hFFFF_FF57, 1'b0, 1'b1, 1'b0);
    step(1'b0, OP_COMP, 32'd7, 32'd0, 5'd0);
    check_all("comp0", 32'd0, 1'b1, 1'b0, 1'b1);

    step(1'b0, OP_AND, 32'd200, 32'd169, 5'd0);
    check_all("and", 32'd136, 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_XOR, 32'd200, 32'd169, 5'd0);
    check_all("xor", 32'd97, 1'b0, 1'b0, 1'b0);

    step(1'b0, OP_SLL, 32'hFFFF_FF91, 32'd0, 5'd4);
    check_all("sll", 32'hFFFF_F910, 1'b0, 1'b1, 1'b0);
    step(1'b0, OP_SRL, 32'd200, 32'd0, 5'd4);
    check_all("srl", 32'd12, 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_SRA, 32'd0, 32'd0, 5'd4);
    check_all("sra0", 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, OP_SRA, 32'h8000_0000, 32'd0, 5'd4);
    check_all("sra_neg", 32'hF800_0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, OP_SRL, 32'h8000_0000, 32'd0, 5'd4);
    check_all("srl_neg", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_SRA, 32'h8765_4321, 32'd0, 5'd0);
    check_all("sra_by0", 32'h8765_4321, 1'b0, 1'b1, 1'b0);
    step(1'b0, OP_SLL, 32'h0000_0003, 32'd0, 5'd31);
    check_all("sll31", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

`ifdef ALU_VARSHIFT_EN
    step(1'b0, OP_SLLV, 32'd200, 32'hFFFF_FFE3, 5'd9);
    check_all("sllv", 32'd1600, 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_SRLV, 32'd200, 32'hFFFF_FFE3, 5'd9);
    check_all("srlv", 32'd25, 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_SRAV, 32'd200, 32'hFFFF_FFE3, 5'd9);
    check_all("srav", 32'd25, 1'b0, 1'b0, 1'b0);
`else
    step(1'b0, OP_SLLV, 32'd200, 32'd3, 5'd1);
    check_all("sllv_off", 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, OP_SRLV, 32'd200, 32'd3, 5'd1);
    check_all("srlv_off", 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, OP_SRAV, 32'd200, 32'd3, 5'd1);
    check_all("srav_off", 32'd0, 1'b0, 1'b0, 1'b1);
`endif

    step(1'b0, OP_SUB, 32'd200, 32'd169, 5'd0);
    check_all("sub", 32'd31, 1'b1, 1'b0, 1'b0);
    step(1'b0, OP_SUB, 32'd169, 32'd200, 5'd0);
    check_all("sub_neg", 32'hFFFF_FFE1, 1'b0, 1'b1, 1'b0);

    step(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check_all("pre_bad", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'b1111, 32'd200, 32'd169, 5'd3);
    check_all("op1111", 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    step(1'b0, 4'b1000, 32'd200, 32'd169, 5'd3);
    check_all("op1000", 32'd0, 1'b0, 1'b0, 1'b1);

    step(1'b0, OP_SUB, 32'd169, 32'd200, 5'd0);
    step(1'b1, OP_ADD, 32'd200, 32'd169, 5'd0);
    check_all("mid_rst", 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, OP_ADD, 32'd200, 32'd169, 5'd0);
    check_all("post_rst", 32'd369, 1'b0, 1'b0, 1'b0);

    drive(1'b0, OP_XOR, 32'd200, 32'd169, 5'd0);
    #1;
    check("lat_hold", out, 32'd369);
    @(posedge clk);
    #1;
    check("lat_one", out, 32'd97);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL have port inp1, input, 32 bits, signed operand A.
REQ-004 The block SHALL have port inp2, input, 32 bits, signed operand B, also the variable shift amount source.
REQ-005 The block SHALL have port shamt, input, 5 bits, immediate shift amount.
REQ-006 The block SHALL have port ALUControl, input, 4 bits, operation select.
REQ-007 The block SHALL have port out, output, 32 bits, signed registered result.
REQ-008 The block SHALL have port carry_out, output, 1 bit, registered carry flag.
REQ-009 The block SHALL have port isNeg, output, 1 bit, registered flag, out[31].
REQ-010 The block SHALL have port isZero, output, 1 bit, registered flag, out == 0.

Function
REQ-011 All outputs SHALL be registered: inputs sampled at a rising clk edge appear on the outputs after that edge, with 1-cycle latency and no handshake.
REQ-012 ALUControl 0000 (ADD) SHALL compute out = inp1 + inp2, with carry_out = carry out of bit 31.
REQ-013 ALUControl 0001 (COMP) SHALL compute out = ~inp2 + 1, with carry_out = carry out of that addition (1 only when inp2 = 0).
REQ-014 ALUControl 0010 (AND) SHALL compute out = inp1 & inp2; 0011 (XOR) SHALL compute out = inp1 ^ inp2; carry_out SHALL be 0 for both.
REQ-015 ALUControl 0100/0101/0110 SHALL compute SLL, SRL and SRA of inp1 by shamt respectively.
REQ-016 ALUControl 1100/1101/1110 SHALL compute SLL, SRL and SRA of inp1 by inp2[4:0] respectively; inp2[31:5] SHALL be ignored.
REQ-017 For all shifts, carry_out SHALL be 0, and a shift amount of 0 SHALL pass inp1 through unchanged.
REQ-018 SRL SHALL zero-fill; SRA SHALL fill with inp1[31].
REQ-019 ALUControl 0111 (SUB) SHALL compute out = inp1 + ~inp2 + 1, with carry_out = carry out of bit 31 (1 means no borrow).
REQ-020 Overflow SHALL wrap modulo 2^32 with no overflow flag.
REQ-021 Any unlisted ALUControl code SHALL give out = 0 and carry_out = 0.
REQ-022 isZero and isNeg SHALL always be derived from the same cycle's registered out value.

Reset
REQ-023 When rst is sampled high at a clk edge: out = 0, carry_out = 0, isNeg = 0, isZero = 1.
REQ-024 Reset SHALL take priority over any operation in progress; the first valid result appears at the first edge with rst low.

Configuration
REQ-025 With macro ALU_VARSHIFT_EN defined, codes 1100/1101/1110 SHALL be implemented as in REQ-016.
REQ-026 Without ALU_VARSHIFT_EN, codes 1100/1101/1110 SHALL behave as unlisted codes (REQ-021).

Structure
REQ-027 Package alu_pkg SHALL hold the data width constant (32) and the named ALUControl opcode constants.
REQ-028 A single sub-module, alu_shifter, SHALL implement the 32-bit barrel shifter (inputs: data, amount, direction, arithmetic), used for both immediate and variable shifts.

Verification
REQ-029 ADD: 200 + 169 -> out 369, carry 0, zero 0, neg 0; ADD: 0xFFFFFFFF + 1 -> out 0, carry 1, zero 1.
REQ-030 COMP inp2 = 169 -> out -169 (0xFFFFFF57), neg 1, carry 0; AND 200 & 169 -> 136; XOR 200 ^ 169 -> 97.
REQ-031 SLL -111 by shamt 4 -> -1776, neg 1; SRL 200 by shamt 4 -> 12; SRA 0 by shamt 4 -> 0, zero 1; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-032 With ALU_VARSHIFT_EN: 1100/1101/1110 on 200 with inp2 = 3 -> 1600/25/25; without the macro -> out 0, zero 1.
REQ-033 SUB 200 - 169 -> 31, carry 1; SUB 169 - 200 -> -31, carry 0, neg 1; unlisted code 1111 -> out 0.
REQ-034 Assert rst for one edge mid-stream -> outputs out 0, carry 0, neg 0, zero 1 that cycle; the next edge shows the current inputs' result; latency SHALL be checked as exactly one cycle.
